// File: rtl/control_fsm_param_if.sv
// Datapath/memory control bundle between the processor control unit and its datapath.
// Instruction and memory-ack inputs flow to the controller; enables and selects flow back.
interface control_fsm_param_if #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8
);
    localparam int unsigned SW = $clog2(NREG + 4);

    logic [DW-1:0]   IR;
    logic            mem_ack;
    logic [SW-1:0]   select;
    logic [NREG-1:0] Rin;
    logic            IRin;
    logic            Ain;
    logic            Gin;
    logic [1:0]      alu_op;
    logic            ADDRin;
    logic            DOUTin;
    logic            mem_req;
    logic            mem_wr;

    modport master (
        input  IR, mem_ack,
        output select, Rin, IRin, Ain, Gin, alu_op, ADDRin, DOUTin, mem_req, mem_wr
    );

    modport slave (
        output IR, mem_ack,
        input  select, Rin, IRin, Ain, Gin, alu_op, ADDRin, DOUTin, mem_req, mem_wr
    );
endinterface

// File: rtl/control_fsm_param.sv
// Control unit for the simple processor: sequences one instruction per run request,
// including load/store through a req/ack memory handshake with an optional timeout.
module control_fsm_param #(
    parameter int unsigned DW       = 16,
    parameter int unsigned NREG     = 8,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    control_fsm_param_if.master bus,
    output logic Done,
    output logic err,
    output logic busy
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned SW = $clog2(NREG + 4);
    localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

    localparam logic [SW-1:0] SEL_G   = SW'(NREG);
    localparam logic [SW-1:0] SEL_D   = SW'(NREG + 1);
    localparam logic [SW-1:0] SEL_DT  = SW'(NREG + 2);
    localparam logic [SW-1:0] SEL_DIN = SW'(NREG + 3);

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVT = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_LD  = 3'd5;
    localparam logic [2:0] OP_ST  = 3'd6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_T1,
        S_T2,
        S_T3,
        S_MEM
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [2:0]      op;
    logic            imm;
    logic [RW-1:0]   rx;
    logic [RW-1:0]   ry;
    logic [NREG-1:0] rx_onehot;
    logic            timeout;
    logic            unused_ir;

    // Instruction field decode; the top IR bit and the gap between rX and rY are don't-care.
    assign op        = bus.IR[DW-2 -: 3];
    assign imm       = bus.IR[DW-5];
    assign rx        = bus.IR[DW-6 -: RW];
    assign ry        = bus.IR[RW-1:0];
    assign rx_onehot = NREG'(1) << rx;
    assign timeout   = (WAIT_MAX != 0) && (wait_cnt == LAST);
    assign unused_ir = ^bus.IR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycles spent in MEM without an ack; zero outside MEM so every entry starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != S_MEM) begin
            wait_cnt <= '0;
        end else if (!bus.mem_ack && (wait_cnt != LAST)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.select  = '0;
        bus.Rin     = '0;
        bus.IRin    = 1'b0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.alu_op  = ALU_ADD;
        bus.ADDRin  = 1'b0;
        bus.DOUTin  = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_wr  = 1'b0;
        Done        = 1'b0;
        err         = 1'b0;
        busy        = (state != S_FETCH);

        case (state)
            S_FETCH: begin
                // Gated by reset so IR is never loaded while the unit is held in reset.
                bus.IRin = run && rst;
                if (run) begin
                    state_nxt = S_T1;
                end
            end

            S_T1: begin
                case (op)
                    OP_MV: begin
                        bus.select = imm ? SEL_D : SW'(ry);
                        bus.Rin    = rx_onehot;
                        Done       = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                    OP_MVT: begin
                        bus.select = SEL_DT;
                        bus.Rin    = rx_onehot;
                        Done       = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus.select = SW'(rx);
                        bus.Ain    = 1'b1;
                        state_nxt  = S_T2;
                    end
                    OP_LD, OP_ST: begin
                        bus.select = SW'(ry);
                        bus.ADDRin = 1'b1;
                        state_nxt  = (op == OP_LD) ? S_MEM : S_T2;
                    end
                    default: begin
                        Done      = 1'b1;
                        err       = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end

            S_T2: begin
                if (op == OP_ST) begin
                    bus.select = SW'(rx);
                    bus.DOUTin = 1'b1;
                    state_nxt  = S_MEM;
                end else begin
                    bus.select = imm ? SEL_D : SW'(ry);
                    bus.Gin    = 1'b1;
                    bus.alu_op = (op == OP_SUB) ? ALU_SUB :
                                 (op == OP_AND) ? ALU_AND : ALU_ADD;
                    state_nxt  = S_T3;
                end
            end

            S_T3: begin
                bus.select = SEL_G;
                bus.Rin    = rx_onehot;
                Done       = 1'b1;
                state_nxt  = S_FETCH;
            end

            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_wr  = (op == OP_ST);
                // An ack arriving on the last allowed cycle still completes normally.
                if (bus.mem_ack) begin
                    if (op == OP_LD) begin
                        bus.select = SEL_DIN;
                        bus.Rin    = rx_onehot;
                    end
                    Done      = 1'b1;
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    Done      = 1'b1;
                    err       = 1'b1;
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_control_fsm_param.sv
// Scoreboard bench for control_fsm_param: two configurations (16-bit/8 regs, 12-bit/4 regs)
// observed through one monitor that summarises each instruction and checks it at Done.
module tb_control_fsm_param;
    typedef struct {
        string name;
        int    lat;
        int    sel_done;
        int    rin;
        int    err;
        int    sel_a;
        int    sel_g;
        int    alu;
        int    sel_ad;
        int    sel_dout;
        int    nreq;
        int    wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run0, run1, ack;
    logic [15:0] ir16;
    logic [11:0] ir12;
    logic        done0, err0, busy0, done1, err1, busy1;
    int          cfg;
    int          ack_delay;
    int          checks = 0;
    int          failures = 0;
    exp_t        sbq[$];

    always #5 clk = ~clk;

    control_fsm_param_if #(.DW(16), .NREG(8)) bus0();
    control_fsm_param_if #(.DW(12), .NREG(4)) bus1();

    assign bus0.IR      = ir16;
    assign bus0.mem_ack = ack;
    assign bus1.IR      = ir12;
    assign bus1.mem_ack = ack;

    control_fsm_param #(.DW(16), .NREG(8), .WAIT_MAX(15)) dut0 (
        .clk(clk), .rst(rst), .run(run0), .bus(bus0), .Done(done0), .err(err0), .busy(busy0)
    );
    control_fsm_param #(.DW(12), .NREG(4), .WAIT_MAX(4)) dut1 (
        .clk(clk), .rst(rst), .run(run1), .bus(bus1), .Done(done1), .err(err1), .busy(busy1)
    );

    int o_sel, o_rin, o_alu;
    logic o_irin, o_ain, o_gin, o_addr, o_dout, o_req, o_wr, o_done, o_err, o_busy;

    always_comb begin
        if (cfg == 0) begin
            o_sel = int'(bus0.select); o_rin = int'(bus0.Rin); o_alu = int'(bus0.alu_op);
            o_irin = bus0.IRin; o_ain = bus0.Ain; o_gin = bus0.Gin; o_addr = bus0.ADDRin;
            o_dout = bus0.DOUTin; o_req = bus0.mem_req; o_wr = bus0.mem_wr;
            o_done = done0; o_err = err0; o_busy = busy0;
        end else begin
            o_sel = int'(bus1.select); o_rin = int'(bus1.Rin); o_alu = int'(bus1.alu_op);
            o_irin = bus1.IRin; o_ain = bus1.Ain; o_gin = bus1.Gin; o_addr = bus1.ADDRin;
            o_dout = bus1.DOUTin; o_req = bus1.mem_req; o_wr = bus1.mem_wr;
            o_done = done1; o_err = err1; o_busy = busy1;
        end
    end

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", n, act, exp);
        end
    endfunction

    function automatic exp_t ex(string n, int lat, int sel_done, int rin, int err, int sel_a,
                                int sel_g, int alu, int sel_ad, int sel_dout, int nreq, int wr);
        exp_t e;
        e.name = n; e.lat = lat; e.sel_done = sel_done; e.rin = rin; e.err = err;
        e.sel_a = sel_a; e.sel_g = sel_g; e.alu = alu; e.sel_ad = sel_ad;
        e.sel_dout = sel_dout; e.nreq = nreq; e.wr = wr;
        return e;
    endfunction

    function automatic logic [15:0] mk16(int op, int imm, int rx, int ry);
        return {1'b0, 3'(op), 1'(imm), 3'(rx), 5'b0, 3'(ry)};
    endfunction

    function automatic logic [15:0] mk12(int op, int imm, int rx, int ry);
        return {4'b0, 1'b0, 3'(op), 1'(imm), 2'(rx), 3'b0, 2'(ry)};
    endfunction

    // Memory responder: ack after ack_delay wait cycles in MEM (negative = never).
    initial begin
        int cnt;
        cnt = 0;
        ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !o_req) begin
                ack = 1'b0;
                cnt = 0;
            end else begin
                ack = (ack_delay >= 0) && (cnt == ack_delay);
                cnt++;
            end
        end
    end

    // Monitor: summarise each instruction from its FETCH cycle, compare at Done.
    initial begin
        bit   active;
        int   lat, m_ain, m_gin, m_addr, m_dout, m_req, m_wr, m_rin, m_nrin;
        int   m_sel_a, m_sel_g, m_alu, m_sel_ad, m_sel_dout;
        exp_t e;
        active = 0;
        lat = 0; m_ain = 0; m_gin = 0; m_addr = 0; m_dout = 0; m_req = 0; m_wr = 0;
        m_rin = 0; m_nrin = 0; m_sel_a = -1; m_sel_g = -1; m_alu = -1; m_sel_ad = -1;
        m_sel_dout = -1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active = 0;
            end else if (!active) begin
                if (o_done) chk("spurious_done", 1, 0);
                if (o_irin) begin
                    active = 1; lat = 0; m_ain = 0; m_gin = 0; m_addr = 0; m_dout = 0;
                    m_req = 0; m_wr = 0; m_rin = 0; m_nrin = 0; m_sel_a = -1; m_sel_g = -1;
                    m_alu = -1; m_sel_ad = -1; m_sel_dout = -1;
                end
            end else begin
                lat++;
                if (o_ain)  begin m_ain++;  m_sel_a = o_sel; end
                if (o_gin)  begin m_gin++;  m_sel_g = o_sel; m_alu = o_alu; end
                if (o_addr) begin m_addr++; m_sel_ad = o_sel; end
                if (o_dout) begin m_dout++; m_sel_dout = o_sel; end
                if (o_req)  begin m_req++;  m_wr = m_wr | int'(o_wr); end
                if (o_rin != 0) m_nrin++;
                m_rin = m_rin | o_rin;
                if (o_err && !o_done) chk("err_without_done", 1, 0);
                if (o_done) begin
                    active = 0;
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk({e.name, ".latency"}, lat, e.lat);
                        chk({e.name, ".sel_done"}, o_sel, e.sel_done);
                        chk({e.name, ".rin"}, m_rin, e.rin);
                        chk({e.name, ".rin_cycles"}, m_nrin, (e.rin != 0) ? 1 : 0);
                        chk({e.name, ".err"}, int'(o_err), e.err);
                        chk({e.name, ".ain_cnt"}, m_ain, (e.sel_a >= 0) ? 1 : 0);
                        chk({e.name, ".sel_a"}, m_sel_a, e.sel_a);
                        chk({e.name, ".gin_cnt"}, m_gin, (e.sel_g >= 0) ? 1 : 0);
                        chk({e.name, ".sel_g"}, m_sel_g, e.sel_g);
                        chk({e.name, ".alu_op"}, m_alu, e.alu);
                        chk({e.name, ".addr_cnt"}, m_addr, (e.sel_ad >= 0) ? 1 : 0);
                        chk({e.name, ".sel_addr"}, m_sel_ad, e.sel_ad);
                        chk({e.name, ".dout_cnt"}, m_dout, (e.sel_dout >= 0) ? 1 : 0);
                        chk({e.name, ".sel_dout"}, m_sel_dout, e.sel_dout);
                        chk({e.name, ".req_cycles"}, m_req, e.nreq);
                        chk({e.name, ".mem_wr"}, m_wr, e.wr);
                    end
                end else if (lat > 100) begin
                    active = 0;
                    chk("done_timeout", lat, -1);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!o_busy) return;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(int c, logic [15:0] ir, int ackd, exp_t e);
        wait_idle();
        cfg = c;
        ack_delay = ackd;
        if (c == 0) begin ir16 = ir; run0 = 1'b1; end
        else begin ir12 = ir[11:0]; run1 = 1'b1; end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        run0 = 1'b0;
        run1 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; run0 = 1'b0; run1 = 1'b0; cfg = 0; ack_delay = -1;
        ir16 = '0; ir12 = '0;

        // Reset state, with run held high to show IR load stays off during reset.
        #11;
        run0 = 1'b1;
        #1;
        chk("rst.busy", int'(o_busy), 0);
        chk("rst.mem_req", int'(o_req), 0);
        chk("rst.done", int'(o_done), 0);
        chk("rst.irin", int'(o_irin), 0);
        chk("rst.rin", o_rin, 0);
        chk("rst.select", o_sel, 0);
        run0 = 1'b0;
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // NREG=8: G=8, D=9, DT=10, DIN=11
        issue(0, mk16(0, 0, 3, 5), -1, ex("mv",      1,  5, 'h08, 0, -1, -1, -1, -1, -1, 0, 0));
        issue(0, mk16(0, 1, 0, 2), -1, ex("mv_imm",  1,  9, 'h01, 0, -1, -1, -1, -1, -1, 0, 0));
        issue(0, mk16(1, 0, 7, 0), -1, ex("mvt",     1, 10, 'h80, 0, -1, -1, -1, -1, -1, 0, 0));
        issue(0, mk16(2, 1, 1, 0), -1, ex("add_imm", 3,  8, 'h02, 0,  1,  9,  0, -1, -1, 0, 0));
        issue(0, mk16(3, 0, 2, 7), -1, ex("sub",     3,  8, 'h04, 0,  2,  7,  1, -1, -1, 0, 0));
        issue(0, mk16(4, 0, 6, 3), -1, ex("and",     3,  8, 'h40, 0,  6,  3,  2, -1, -1, 0, 0));
        issue(0, mk16(5, 0, 2, 4),  3, ex("ld_k3",   5, 11, 'h04, 0, -1, -1, -1,  4, -1, 4, 0));
        issue(0, mk16(5, 0, 5, 1),  0, ex("ld_k0",   2, 11, 'h20, 0, -1, -1, -1,  1, -1, 1, 0));
        issue(0, mk16(6, 0, 6, 0),  2, ex("st_k2",   5,  0, 0,    0, -1, -1, -1,  0,  6, 3, 1));
        issue(0, mk16(6, 0, 6, 0), -1, ex("st_to",  17,  0, 0,    1, -1, -1, -1,  0,  6, 15, 1));
        issue(0, mk16(5, 0, 1, 3), 14, ex("ld_k14", 16, 11, 'h02, 0, -1, -1, -1,  3, -1, 15, 0));
        issue(0, mk16(5, 0, 1, 3), -1, ex("ld_to",  16,  0, 0,    1, -1, -1, -1,  3, -1, 15, 0));
        issue(0, mk16(7, 0, 3, 5), -1, ex("illegal", 1,  0, 0,    1, -1, -1, -1, -1, -1, 0, 0));
        issue(0, mk16(0, 0, 1, 2), -1, ex("mv_b2b",  1,  2, 'h02, 0, -1, -1, -1, -1, -1, 0, 0));

        // Asynchronous reset in the middle of a load that never gets an ack.
        wait_idle();
        cfg = 0; ack_delay = -1; ir16 = mk16(5, 0, 2, 4); run0 = 1'b1;
        @(posedge clk); #1; run0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst.mem_req", int'(o_req), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst.mem_req", int'(o_req), 0);
        chk("mid_rst.busy", int'(o_busy), 0);
        chk("mid_rst.done", int'(o_done), 0);
        chk("mid_rst.rin", o_rin, 0);
        run0 = 1'b1;
        #1;
        chk("mid_rst.irin", int'(o_irin), 0);
        run0 = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        issue(0, mk16(0, 0, 4, 6), -1, ex("mv_post_rst", 1, 6, 'h10, 0, -1, -1, -1, -1, -1, 0, 0));

        // NREG=4, DW=12, WAIT_MAX=4: G=4, D=5, DT=6, DIN=7
        issue(1, mk12(0, 0, 3, 1), -1, ex("n4_mv",    1, 1, 'h08, 0, -1, -1, -1, -1, -1, 0, 0));
        issue(1, mk12(2, 1, 1, 0), -1, ex("n4_add",   3, 4, 'h02, 0,  1,  5,  0, -1, -1, 0, 0));
        issue(1, mk12(5, 0, 2, 0),  3, ex("n4_ld",    5, 7, 'h04, 0, -1, -1, -1,  0, -1, 4, 0));
        issue(1, mk12(6, 0, 3, 1), -1, ex("n4_st_to", 6, 0, 0,    1, -1, -1, -1,  1,  3, 4, 1));
        issue(1, mk12(1, 0, 2, 0), -1, ex("n4_mvt",   1, 6, 'h04, 0, -1, -1, -1, -1, -1, 0, 0));

        wait_idle();
        repeat (3) @(posedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
